// File: rtl/pipe_stall_ctrl_if.sv
// Request/control bundle between the pipeline datapath and pipe_stall_ctrl.
// master = pipeline side (raises requests), slave = the stall sequencer.
interface pipe_stall_ctrl_if;
  logic load_use_hz;
  logic jr_hz;
  logic div_start;
  logic dmem_req;
  logic dmem_ack;
  logic ex_flush;
  logic pc_hold;
  logic IFID_ready;
  logic IDEXE_delete;
  logic idexe_hold;
  logic exmem_hold;
  logic memwb_bubble;
  logic flush_all;
  logic div_busy;
  logic div_done;
  logic div_abort;
  logic mem_timeout;

  modport master (
    output load_use_hz, jr_hz, div_start, dmem_req, dmem_ack, ex_flush,
    input  pc_hold, IFID_ready, IDEXE_delete, idexe_hold, exmem_hold,
           memwb_bubble, flush_all, div_busy, div_done, div_abort, mem_timeout
  );

  modport slave (
    input  load_use_hz, jr_hz, div_start, dmem_req, dmem_ack, ex_flush,
    output pc_hold, IFID_ready, IDEXE_delete, idexe_hold, exmem_hold,
           memwb_bubble, flush_all, div_busy, div_done, div_abort, mem_timeout
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: merges hazards, divider occupancy
// and data-RAM waits. Optional memory timeout: define PIPE_STALL_MEM_TIMEOUT_EN.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES  = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input logic            clk,
  input logic            resetn,
  pipe_stall_ctrl_if.slave sc
);

  if (DIV_CYCLES < 2 || DIV_CYCLES > 31) begin : g_bad_div
    $error("pipe_stall_ctrl: DIV_CYCLES must be 2..31");
  end
  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_tmo
    $error("pipe_stall_ctrl: MEM_TIMEOUT must be 2..255");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LOAD = 5'(DIV_CYCLES - 1);

  state_t     state, state_nx;
  logic [4:0] cnt, cnt_nx;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
  localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] wcnt, wcnt_nx;
`endif

  logic mem_wait, hz, frz;
  logic pc_hold, ifid_ready, idexe_delete, idexe_hold, exmem_hold;
  logic memwb_bubble, flush_all, div_busy, div_done, div_abort, mem_timeout;

  assign mem_wait = sc.dmem_req & ~sc.dmem_ack;
  assign hz       = sc.load_use_hz | sc.jr_hz;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
    wcnt_nx      = wcnt;
`endif
    frz          = 1'b0;
    pc_hold      = 1'b0;
    ifid_ready   = 1'b1;
    idexe_delete = 1'b0;
    idexe_hold   = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    flush_all    = 1'b0;
    div_busy     = 1'b0;
    div_done     = 1'b0;
    div_abort    = 1'b0;
    mem_timeout  = 1'b0;

    if (sc.ex_flush) begin
      flush_all = 1'b1;
      div_abort = (state == DIV_WAIT) | sc.div_start;
      state_nx  = RUN;
      cnt_nx    = '0;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
      wcnt_nx   = '0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            frz          = 1'b1;
            memwb_bubble = 1'b1;
            state_nx     = MEM_WAIT;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
            wcnt_nx      = '0;
`endif
          end else if (sc.div_start) begin
            frz      = 1'b1;
            div_busy = 1'b1;
            cnt_nx   = CNT_LOAD;
            state_nx = DIV_WAIT;
          end else if (hz) begin
            // only the front end stalls; EXE/MEM drain with a bubble behind them
            pc_hold      = 1'b1;
            ifid_ready   = 1'b0;
            idexe_delete = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (sc.dmem_ack) begin
            state_nx = RUN;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
          end else if (wcnt == WCNT_LAST) begin
            mem_timeout = 1'b1;
            flush_all   = 1'b1;
            state_nx    = RUN;
            wcnt_nx     = '0;
`endif
          end else begin
            frz          = 1'b1;
            memwb_bubble = 1'b1;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
            wcnt_nx      = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
`endif
          end
        end
        DIV_WAIT: begin
          div_busy = 1'b1;
          if (mem_wait) begin
            // memory stall overrides, but the divider keeps iterating underneath
            frz          = 1'b1;
            memwb_bubble = 1'b1;
            if (cnt != '0) cnt_nx = cnt - 5'd1;
          end else if (cnt != '0) begin
            frz    = 1'b1;
            cnt_nx = cnt - 5'd1;
          end else begin
            div_done = 1'b1;
            state_nx = RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end

    if (frz) begin
      pc_hold    = 1'b1;
      ifid_ready = 1'b0;
      idexe_hold = 1'b1;
      exmem_hold = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      cnt   <= '0;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
      wcnt  <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
      wcnt  <= wcnt_nx;
`endif
    end
  end

  assign sc.pc_hold      = pc_hold;
  assign sc.IFID_ready   = ifid_ready;
  assign sc.IDEXE_delete = idexe_delete;
  assign sc.idexe_hold   = idexe_hold;
  assign sc.exmem_hold   = exmem_hold;
  assign sc.memwb_bubble = memwb_bubble;
  assign sc.flush_all    = flush_all;
  assign sc.div_busy     = div_busy;
  assign sc.div_done     = div_done;
  assign sc.div_abort    = div_abort;
  assign sc.mem_timeout  = mem_timeout;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a cycle-level reference model checked
// every negedge, plus literal expectations at key cycles of each scenario.
module tb_pipe_stall_ctrl;
  localparam int DIVC = 8;
  localparam int MTO  = 4;

  // output vector: {pc_hold, IFID_ready, IDEXE_delete, idexe_hold, exmem_hold,
  //                 memwb_bubble, flush_all, div_busy, div_done, div_abort, mem_timeout}
  localparam logic [10:0] IDLE      = 11'b01000000000;
  localparam logic [10:0] HAZ       = 11'b10100000000;
  localparam logic [10:0] FRZ_DIV   = 11'b10011001000;
  localparam logic [10:0] FRZ_MEM   = 11'b10011100000;
  localparam logic [10:0] FRZ_MEMDV = 11'b10011101000;
  localparam logic [10:0] DONE      = 11'b01000001100;
  localparam logic [10:0] FLUSH     = 11'b01000010000;
  localparam logic [10:0] FLUSH_AB  = 11'b01000010010;
  localparam logic [10:0] TIMEOUT   = 11'b01000010001;

  logic clk = 1'b0;
  logic resetn;
  int   passed = 0;
  int   total  = 0;

  pipe_stall_ctrl_if sif();

  pipe_stall_ctrl #(.DIV_CYCLES(DIVC), .MEM_TIMEOUT(MTO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sc     (sif.slave)
  );

  always #5 clk = ~clk;

  logic [10:0] outv;
  assign outv = {sif.pc_hold, sif.IFID_ready, sif.IDEXE_delete, sif.idexe_hold,
                 sif.exmem_hold, sif.memwb_bubble, sif.flush_all, sif.div_busy,
                 sif.div_done, sif.div_abort, sif.mem_timeout};

  task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
  endtask

  // Reference model: tracks "waiting on memory", how many frozen divide cycles
  // have elapsed, and how long the memory wait has lasted.
  bit in_mem;
  int div_seen;
  int waited;

  always @(negedge clk) begin
    logic [10:0] e;
    logic mw;
    if (!resetn) begin
      in_mem = 0; div_seen = 0; waited = 0;
    end
    mw = sif.dmem_req & ~sif.dmem_ack;
    e  = IDLE;
    if (sif.ex_flush) begin
      e = FLUSH;
      e[1] = (div_seen > 0) | sif.div_start;
      if (resetn) begin in_mem = 0; div_seen = 0; waited = 0; end
    end else if (in_mem) begin
      if (sif.dmem_ack) begin
        e = IDLE;
        if (resetn) in_mem = 0;
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
      end else if (waited == MTO - 1) begin
        e = TIMEOUT;
        if (resetn) in_mem = 0;
`endif
      end else begin
        e = FRZ_MEM;
        if (resetn && waited < 255) waited++;
      end
    end else if (div_seen > 0) begin
      if (mw) begin
        e = FRZ_MEMDV;
        if (resetn && div_seen < DIVC) div_seen++;
      end else if (div_seen < DIVC) begin
        e = FRZ_DIV;
        if (resetn) div_seen++;
      end else begin
        e = DONE;
        if (resetn) div_seen = 0;
      end
    end else begin
      if (mw) begin
        e = FRZ_MEM;
        if (resetn) begin in_mem = 1; waited = 0; end
      end else if (sif.div_start) begin
        e = FRZ_DIV;
        if (resetn) div_seen = 1;
      end else if (sif.load_use_hz | sif.jr_hz) begin
        e = HAZ;
      end
    end
    chk("model", outv, e);
  end

  // v = {load_use_hz, jr_hz, div_start, dmem_req, dmem_ack, ex_flush}
  task automatic drive(input logic [5:0] v);
    @(posedge clk);
    #1;
    {sif.load_use_hz, sif.jr_hz, sif.div_start, sif.dmem_req, sif.dmem_ack, sif.ex_flush} = v;
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    {sif.load_use_hz, sif.jr_hz, sif.div_start, sif.dmem_req, sif.dmem_ack, sif.ex_flush} = '0;
    repeat (2) @(posedge clk);
    #2 chk("reset", outv, IDLE);
    @(posedge clk);
    #1 resetn = 1'b1;

    drive(6'b000000); chk("idle", outv, IDLE);
    drive(6'b100000); chk("load_use", outv, HAZ);
    drive(6'b000000); chk("after_load_use", outv, IDLE);
    drive(6'b010000); chk("jr", outv, HAZ);
    drive(6'b000110); chk("req_ack_same", outv, IDLE);
    drive(6'b000001); chk("flush_run", outv, FLUSH);

    // two back-to-back divides
    for (int c = 0; c < 18; c++) begin
      drive(6'b001000);
      if (c == 0)  chk("div_c0", outv, FRZ_DIV);
      if (c == 7)  chk("div_c7", outv, FRZ_DIV);
      if (c == 8)  chk("div_done", outv, DONE);
      if (c == 9)  chk("div2_start", outv, FRZ_DIV);
      if (c == 17) chk("div2_done", outv, DONE);
    end
    drive(6'b000000); chk("idle_after_div", outv, IDLE);

    // memory wait ahead of a pending divide
    for (int c = 0; c < 14; c++) begin
      drive({2'b00, 1'b1, c <= 4, c == 4, 1'b0});
      if (c == 0)  chk("mem_c0", outv, FRZ_MEM);
      if (c == 3)  chk("mem_c3", outv, FRZ_MEM);
      if (c == 4)  chk("mem_ack", outv, IDLE);
      if (c == 5)  chk("div_after_mem", outv, FRZ_DIV);
      if (c == 12) chk("div_after_mem_c12", outv, FRZ_DIV);
      if (c == 13) chk("div_after_mem_done", outv, DONE);
    end
    drive(6'b000000);

    // memory wait arising inside a divide
    for (int c = 0; c < 9; c++) begin
      drive({2'b00, 1'b1, c == 2 || c == 3, 2'b00});
      if (c == 2) chk("mem_in_div", outv, FRZ_MEMDV);
      if (c == 8) chk("mem_in_div_done", outv, DONE);
    end
    drive(6'b000000);

    // flush on divide cycle 3
    for (int c = 0; c < 4; c++) begin
      drive({2'b00, 1'b1, 2'b00, c == 3});
      if (c == 3) chk("flush_div", outv, FLUSH_AB);
    end
    for (int c = 0; c < 10; c++) begin
      drive(6'b000000);
      if (c == 0 || c == 6) chk("no_done_after_flush", outv, IDLE);
    end

    // asynchronous reset with cnt=3
    for (int c = 0; c < 5; c++) drive(6'b001000);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    {sif.load_use_hz, sif.jr_hz, sif.div_start, sif.dmem_req, sif.dmem_ack, sif.ex_flush} = '0;
    #1 chk("reset_mid_div", outv, IDLE);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(6'b000000);
      if (c == 5) chk("no_done_after_reset", outv, IDLE);
    end

    // memory request with no ack
    for (int c = 0; c < 8; c++) begin
      drive(6'b000100);
      if (c == 3) chk("stuck_c3", outv, FRZ_MEM);
`ifdef PIPE_STALL_MEM_TIMEOUT_EN
      if (c == 4) chk("timeout", outv, TIMEOUT);
`else
      if (c == 4) chk("no_timeout", outv, FRZ_MEM);
`endif
      if (c == 7) chk("stuck_c7", outv, FRZ_MEM);
    end
    drive(6'b000110); chk("late_ack", outv, IDLE);
    drive(6'b000000);

    // ack coinciding with the timeout cycle
    for (int c = 0; c < 5; c++) begin
      drive({3'b000, 1'b1, c == 4, 1'b0});
      if (c == 4) chk("ack_beats_timeout", outv, IDLE);
    end
    repeat (3) drive(6'b000000);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
